// File: rtl/pa_iu_div_radix_unit.sv
// Iterative radix-2^RADIX_BITS integer divider with normalisation, early exit,
// signed fix-up and valid/ready handshakes on request and response.
//
// state | meaning
// IDLE  | waiting for a request; req_rdy high
// PREP  | form magnitudes, resolve special cases, size the iteration count
// ITER  | produce RADIX_BITS quotient bits per cycle
// DONE  | result held on rsp_* until rsp_rdy
module pa_iu_div_radix_unit #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic            div_clk,
  input  logic            cpurst,
  input  logic            div_flush,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [XLEN-1:0] req_src0,
  input  logic [XLEN-1:0] req_src1,
  input  logic            req_signed,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rsp_quot,
  output logic [XLEN-1:0] rsp_rem,
  output logic            rsp_dbz
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int PW = XLEN + RADIX_BITS + 1;
  localparam int NM = 1 << RADIX_BITS;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t                state, state_nxt;
  logic [XLEN-1:0]       src0_q, src1_q;
  logic                  signed_q;
  logic [XLEN-1:0]       rem_q, quot_q;
  logic [CW-1:0]         cnt_q;

  logic [XLEN-1:0]       a_abs, b_abs;
  logic [CW-1:0]         lz_d, cnt_init, sh;
  logic [PW-1:0]         prod, sel_prod;
  logic [RADIX_BITS-1:0] sel_m;
  logic [XLEN-1:0]       iter_q, iter_r;
  logic                  neg_q, neg_r, is_ovf;
  logic                  accept, done_en, rsp_clr, fin_dbz;
  logic [XLEN-1:0]       fin_quot, fin_rem;

  function automatic logic [CW-1:0] lz(input logic [XLEN-1:0] v);
    lz = CW'(XLEN);
    for (int i = 0; i < XLEN; i++)
      if (v[i]) lz = CW'(XLEN - 1 - i);
  endfunction

  assign req_rdy = (state == IDLE) && !cpurst;

  always_comb begin : dp
    a_abs    = (signed_q && src0_q[XLEN-1]) ? -src0_q : src0_q;
    b_abs    = (signed_q && src1_q[XLEN-1]) ? -src1_q : src1_q;
    neg_q    = signed_q && (src0_q[XLEN-1] ^ src1_q[XLEN-1]);
    neg_r    = signed_q && src0_q[XLEN-1];
    is_ovf   = signed_q && (src0_q == MIN_VAL) && (src1_q == '1);
    // a >= b is guaranteed whenever these two are consumed
    lz_d     = lz(b_abs) - lz(a_abs);
    cnt_init = (lz_d + CW'(RADIX_BITS)) >> (RADIX_BITS - 1);
    sh       = (cnt_q - CW'(1)) << (RADIX_BITS - 1);
    prod     = '0;
    sel_prod = '0;
    sel_m    = '0;
    // multiples grow with m, so the last one that fits is the largest
    for (int m = 1; m < NM; m++) begin
      prod = (PW'(b_abs) * PW'(m)) << sh;
      if (prod <= PW'(rem_q)) begin
        sel_m    = RADIX_BITS'(m);
        sel_prod = prod;
      end
    end
    iter_q = (quot_q << RADIX_BITS) | XLEN'(sel_m);
    iter_r = XLEN'(PW'(rem_q) - sel_prod);
  end

  always_comb begin : fsm
    state_nxt = state;
    accept    = 1'b0;
    done_en   = 1'b0;
    rsp_clr   = 1'b0;
    fin_dbz   = 1'b0;
    fin_quot  = '0;
    fin_rem   = '0;
    case (state)
      IDLE: if (req_vld) begin
        accept    = 1'b1;
        state_nxt = PREP;
      end
      PREP: begin
        if (src1_q == '0) begin
          fin_quot  = '1;
          fin_rem   = src0_q;
          fin_dbz   = 1'b1;
          done_en   = 1'b1;
          state_nxt = DONE;
        end else if (is_ovf) begin
          fin_quot  = MIN_VAL;
          done_en   = 1'b1;
          state_nxt = DONE;
        end else if (a_abs < b_abs) begin
          fin_rem   = neg_r ? -a_abs : a_abs;
          done_en   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = ITER;
        end
      end
      ITER: if (cnt_q == CW'(1)) begin
        fin_quot  = neg_q ? -iter_q : iter_q;
        fin_rem   = neg_r ? -iter_r : iter_r;
        done_en   = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (rsp_rdy) begin
        rsp_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (div_flush) begin
      accept    = 1'b0;
      done_en   = 1'b0;
      rsp_clr   = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge div_clk) begin
    if (cpurst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge div_clk) begin
    if (cpurst) begin
      src0_q   <= '0;
      src1_q   <= '0;
      signed_q <= 1'b0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      rsp_vld  <= 1'b0;
      rsp_quot <= '0;
      rsp_rem  <= '0;
      rsp_dbz  <= 1'b0;
    end else begin
      if (accept) begin
        src0_q   <= req_src0;
        src1_q   <= req_src1;
        signed_q <= req_signed;
      end
      if (state == PREP) begin
        rem_q  <= a_abs;
        quot_q <= '0;
        cnt_q  <= cnt_init;
      end else if (state == ITER) begin
        rem_q  <= iter_r;
        quot_q <= iter_q;
        cnt_q  <= cnt_q - CW'(1);
      end
      if (done_en) begin
        rsp_vld  <= 1'b1;
        rsp_quot <= fin_quot;
        rsp_rem  <= fin_rem;
        rsp_dbz  <= fin_dbz;
      end else if (rsp_clr) begin
        rsp_vld <= 1'b0;
        if (div_flush) rsp_dbz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pa_iu_div_radix_unit.sv
// Scoreboard bench: one radix-4 and one radix-2 divider share stimulus; expected
// results and latencies come from a behavioural model and are queued per instance.
module tb_pa_iu_div_radix_unit;

  logic        div_clk = 1'b0;
  logic        cpurst = 1'b1;
  logic        div_flush = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_signed = 1'b0;
  logic        rsp_rdy = 1'b1;
  logic [31:0] req_src0 = '0;
  logic [31:0] req_src1 = '0;

  logic        req_rdy0, rsp_vld0, rsp_dbz0, req_rdy1, rsp_vld1, rsp_dbz1;
  logic [31:0] rsp_quot0, rsp_rem0, rsp_quot1, rsp_rem1;

  typedef struct {
    logic [31:0] quot;
    logic [31:0] rem;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_assert = 0;
  int   n_fail = 0;
  bit   seen[2];

  pa_iu_div_radix_unit #(.XLEN(32), .RADIX_BITS(2)) u_dut_r2 (
    .div_clk(div_clk), .cpurst(cpurst), .div_flush(div_flush),
    .req_vld(req_vld), .req_rdy(req_rdy0), .req_src0(req_src0),
    .req_src1(req_src1), .req_signed(req_signed), .rsp_vld(rsp_vld0),
    .rsp_rdy(rsp_rdy), .rsp_quot(rsp_quot0), .rsp_rem(rsp_rem0),
    .rsp_dbz(rsp_dbz0));

  pa_iu_div_radix_unit #(.XLEN(32), .RADIX_BITS(1)) u_dut_r1 (
    .div_clk(div_clk), .cpurst(cpurst), .div_flush(div_flush),
    .req_vld(req_vld), .req_rdy(req_rdy1), .req_src0(req_src0),
    .req_src1(req_src1), .req_signed(req_signed), .rsp_vld(rsp_vld1),
    .rsp_rdy(rsp_rdy), .rsp_quot(rsp_quot1), .rsp_rem(rsp_rem1),
    .rsp_dbz(rsp_dbz1));

  always #5 div_clk = ~div_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int msb(input logic [31:0] v);
    int r = -1;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Latency counts cycles from the handshake cycle (index 0) to the first rsp_vld cycle
  function automatic exp_t model(input logic [31:0] s0, input logic [31:0] s1,
                                 input logic sg, input int rb);
    exp_t        e;
    logic [31:0] a, b;
    int          d;
    e.quot = '0; e.rem = '0; e.dbz = 1'b0; e.lat = 2;
    if (s1 == 32'd0) begin
      e.quot = 32'hFFFF_FFFF; e.rem = s0; e.dbz = 1'b1;
    end else if (sg && s0 == 32'h8000_0000 && s1 == 32'hFFFF_FFFF) begin
      e.quot = 32'h8000_0000; e.rem = 32'd0;
    end else begin
      if (sg) begin
        e.quot = $signed(s0) / $signed(s1);
        e.rem  = $signed(s0) % $signed(s1);
      end else begin
        e.quot = s0 / s1;
        e.rem  = s0 % s1;
      end
      a = (sg && s0[31]) ? -s0 : s0;
      b = (sg && s1[31]) ? -s1 : s1;
      if (a >= b) begin
        d = msb(a) - msb(b);
        e.lat = 2 + (d + rb) / rb;
      end
    end
    return e;
  endfunction

  task automatic drive(input logic [31:0] s0, input logic [31:0] s1, input logic sg);
    req_src0 = s0; req_src1 = s1; req_signed = sg; req_vld = 1'b1;
  endtask

  task automatic issue(input logic [31:0] s0, input logic [31:0] s1, input logic sg);
    sb0.push_back(model(s0, s1, sg, 2));
    sb1.push_back(model(s0, s1, sg, 1));
    drive(s0, s1, sg);
  endtask

  task automatic check_rsp(input int idx, input int cyc, input logic vld,
                           input logic [31:0] q, input logic [31:0] r, input logic dz);
    exp_t  e;
    int    sz;
    string nm;
    nm = (idx == 0) ? "rb2" : "rb1";
    if (vld && !seen[idx]) begin
      seen[idx] = 1'b1;
      sz = (idx == 0) ? sb0.size() : sb1.size();
      check({nm, "_sb_empty"}, 64'(sz == 0), 64'd0);
      if (sz > 0) begin
        e = (idx == 0) ? sb0.pop_front() : sb1.pop_front();
        check({nm, "_lat"}, 64'(cyc), 64'(e.lat));
        check({nm, "_quot"}, 64'(q), 64'(e.quot));
        check({nm, "_rem"}, 64'(r), 64'(e.rem));
        check({nm, "_dbz"}, 64'(dz), 64'(e.dbz));
      end
    end
  endtask

  task automatic wait_rsp(input int budget);
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge div_clk); #1;
      if (cyc == 1) req_vld = 1'b0;
      check_rsp(0, cyc, rsp_vld0, rsp_quot0, rsp_rem0, rsp_dbz0);
      check_rsp(1, cyc, rsp_vld1, rsp_quot1, rsp_rem1, rsp_dbz1);
      if (seen[0] && seen[1]) break;
    end
    check("rsp_timeout", {62'd0, seen[0], seen[1]}, 64'd3);
  endtask

  task automatic run_op(input logic [31:0] s0, input logic [31:0] s1, input logic sg);
    @(posedge div_clk); #1;
    check("rb2_rdy_idle", 64'(req_rdy0), 64'd1);
    check("rb1_rdy_idle", 64'(req_rdy1), 64'd1);
    issue(s0, s1, sg);
    wait_rsp(60);
  endtask

  task automatic expect_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge div_clk); #1;
      check("rb2_no_rsp", 64'(rsp_vld0), 64'd0);
      check("rb1_no_rsp", 64'(rsp_vld1), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] s0, s1;
    logic        sg;

    repeat (2) @(posedge div_clk);
    #1;
    check("rdy_in_reset", 64'(req_rdy0), 64'd0);
    check("vld_in_reset", 64'(rsp_vld0), 64'd0);
    cpurst = 1'b0;
    #1;
    check("rst_rdy", {62'd0, req_rdy0, req_rdy1}, 64'd3);
    check("rst_quot", 64'(rsp_quot0), 64'd0);
    check("rst_rem", 64'(rsp_rem1), 64'd0);
    check("rst_dbz", {62'd0, rsp_dbz0, rsp_dbz1}, 64'd0);

    run_op(32'd100, 32'd7, 1'b0);
    run_op(-32'sd7, 32'd2, 1'b1);
    run_op(32'd7, -32'sd2, 1'b1);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(-32'sd5, 32'd0, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'd3, 32'd10, 1'b0);
    run_op(-32'sd3, 32'd10, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1);

    // Flush during the second ITER cycle
    @(posedge div_clk); #1;
    drive(32'd100, 32'd7, 1'b0);
    @(posedge div_clk); #1;
    req_vld = 1'b0;
    repeat (2) @(posedge div_clk);
    #1;
    div_flush = 1'b1;
    @(posedge div_clk); #1;
    div_flush = 1'b0;
    check("flush_rdy", {62'd0, req_rdy0, req_rdy1}, 64'd3);
    check("flush_vld", {62'd0, rsp_vld0, rsp_vld1}, 64'd0);
    expect_quiet(6);
    run_op(32'd9, 32'd3, 1'b0);

    // Reset at the same point
    @(posedge div_clk); #1;
    drive(32'd100, 32'd7, 1'b0);
    @(posedge div_clk); #1;
    req_vld = 1'b0;
    repeat (2) @(posedge div_clk);
    #1;
    cpurst = 1'b1;
    @(posedge div_clk); #1;
    check("rst_mid_rdy", {62'd0, req_rdy0, req_rdy1}, 64'd0);
    cpurst = 1'b0;
    #1;
    check("rst_mid_rdy_rel", {62'd0, req_rdy0, req_rdy1}, 64'd3);
    check("rst_mid_quot", 64'(rsp_quot0), 64'd0);
    expect_quiet(6);
    run_op(32'd9, 32'd3, 1'b0);

    // A request coinciding with flush is dropped
    @(posedge div_clk); #1;
    drive(32'd9, 32'd3, 1'b0);
    div_flush = 1'b1;
    @(posedge div_clk); #1;
    req_vld = 1'b0;
    div_flush = 1'b0;
    check("flush_req_rdy", {62'd0, req_rdy0, req_rdy1}, 64'd3);
    expect_quiet(6);

    // Backpressure in DONE, then release with a request in the handshake cycle
    rsp_rdy = 1'b0;
    run_op(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge div_clk); #1;
      check("bp_vld", {62'd0, rsp_vld0, rsp_vld1}, 64'd3);
      check("bp_quot0", 64'(rsp_quot0), 64'd14);
      check("bp_rem0", 64'(rsp_rem0), 64'd2);
      check("bp_quot1", 64'(rsp_quot1), 64'd14);
      check("bp_rem1", 64'(rsp_rem1), 64'd2);
      check("bp_rdy", {62'd0, req_rdy0, req_rdy1}, 64'd0);
    end
    rsp_rdy = 1'b1;
    drive(32'd9, 32'd3, 1'b0);
    @(posedge div_clk); #1;
    req_vld = 1'b0;
    check("bp_rel_rdy", {62'd0, req_rdy0, req_rdy1}, 64'd3);
    check("bp_rel_vld", {62'd0, rsp_vld0, rsp_vld1}, 64'd0);
    expect_quiet(6);

    for (int k = 0; k < 12; k++) begin
      s0 = $urandom;
      s1 = $urandom >> $urandom_range(0, 31);
      sg = 1'($urandom_range(0, 1));
      run_op(s0, s1, sg);
    end

    check("sb_leftover", 64'(sb0.size() + sb1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
